// File: rtl/jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jump_ctrl
//  Purpose  : Pipeline sequencing controller. Arbitrates PC redirection between
//             EX-stage mispredict recovery and ID-stage predicted jumps, and
//             produces stall/flush vectors for load-use hazards and
//             multi-cycle divider holds.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 system clock
//    rstn                asynchronous active-low reset
//    prd_jump_en_i       predictor requests a taken jump (ID)
//    prd_jump_addr_i     predicted target
//    ex_redirect_en_i    EX resolved a mispredict, redirect required
//    ex_redirect_addr_i  correct target from EX
//    ld_use_i            load-use hazard detected in ID
//    div_start_i         divider op entering EX this cycle
//    div_done_i          divider result valid
//    pc_jump_en_o        redirect PC this cycle
//    pc_jump_addr_o      redirect target (0 when no redirect)
//    stall_o             hold: bit0 pc, bit1 if_id, bit2 id_ex
//    flush_o             bubble insert: bit0 if_id, bit1 id_ex
//    div_timeout_o       one-cycle pulse after a divider wait timed out
//    state_o             current FSM state (debug)
//    prd_cnt_o           accepted predictor jumps   (JUMP_CTRL_PERF_EN only)
//    miss_cnt_o          EX redirect cycles          (JUMP_CTRL_PERF_EN only)
//
//  Build option
//    JUMP_CTRL_PERF_EN   when defined, adds the two 32-bit performance counters
// ============================================================================
module jump_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              prd_jump_en_i,
  input  logic [ADDR_W-1:0] prd_jump_addr_i,
  input  logic              ex_redirect_en_i,
  input  logic [ADDR_W-1:0] ex_redirect_addr_i,
  input  logic              ld_use_i,
  input  logic              div_start_i,
  input  logic              div_done_i,
  output logic              pc_jump_en_o,
  output logic [ADDR_W-1:0] pc_jump_addr_o,
  output logic [2:0]        stall_o,
  output logic [1:0]        flush_o,
  output logic              div_timeout_o,
  output logic [1:0]        state_o
`ifdef JUMP_CTRL_PERF_EN
  ,
  output logic [31:0]       prd_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_RECOVER  = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  // Counter value of the last DIV_WAIT cycle before a forced exit.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             prd_accept;

  // --------------------------------------------------------------------------
  // Arbitration: outputs and next state are decoded from the current state and
  // inputs in strict priority order.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_jump_en_o   = 1'b0;
    pc_jump_addr_o = '0;
    stall_o        = 3'b000;
    flush_o        = 2'b00;
    state_d        = ST_RUN;
    cnt_d          = '0;
    timeout_d      = 1'b0;
    prd_accept     = 1'b0;

    if (ex_redirect_en_i) begin
      // Mispredict recovery overrides everything, including a divider hold
      // (the divide in EX is on the wrong path and is abandoned silently).
      pc_jump_en_o   = 1'b1;
      pc_jump_addr_o = ex_redirect_addr_i;
      flush_o        = 2'b11;
      state_d        = ST_RECOVER;
    end else begin
      case (state_q)
        ST_DIV_WAIT: begin
          if (div_done_i) begin
            state_d = ST_RUN;
          end else if (cnt_q == C_CNT_LAST) begin
            // Give up on the divider: release the pipe now, flag it next cycle.
            state_d   = ST_RUN;
            timeout_d = 1'b1;
          end else begin
            stall_o = 3'b111;
            state_d = ST_DIV_WAIT;
            cnt_d   = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end

        ST_RUN, ST_RECOVER: begin
          if (div_start_i) begin
            // A divide that completes in its first cycle needs no hold; it
            // still owns this cycle, so lower-priority requests are dropped.
            if (!div_done_i) begin
              stall_o = 3'b111;
              state_d = ST_DIV_WAIT;
            end
          end else if (ld_use_i) begin
            stall_o = 3'b011;
            flush_o = 2'b10;
          end else if (prd_jump_en_i && (state_q == ST_RUN)) begin
            // In RECOVER the ID stage holds a flushed bubble, so any
            // predictor request there is stale and must be ignored.
            pc_jump_en_o   = 1'b1;
            pc_jump_addr_o = prd_jump_addr_i;
            flush_o        = 2'b01;
            prd_accept     = 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: drive nothing and return to RUN.
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, wait counter and timeout pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign div_timeout_o = timeout_q;
  assign state_o       = state_q;

`ifdef JUMP_CTRL_PERF_EN
  logic [31:0] prd_cnt_q;
  logic [31:0] miss_cnt_q;

  // Free-running event counters; wrap modulo 2^32 by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prd_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (prd_accept) begin
        prd_cnt_q <= prd_cnt_q + 32'd1;
      end
      if (ex_redirect_en_i) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign prd_cnt_o  = prd_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  // Acceptance strobe only feeds the performance counters.
  logic unused_prd_accept;
  assign unused_prd_accept = prd_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jump_ctrl
//  Purpose  : Self-checking bench for jump_ctrl: directed scenarios followed by
//             randomized traffic, all compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jump_ctrl;

  localparam int ADDR_W      = 32;
  localparam int DIV_TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              rstn;
  logic              prd_jump_en_i;
  logic [ADDR_W-1:0] prd_jump_addr_i;
  logic              ex_redirect_en_i;
  logic [ADDR_W-1:0] ex_redirect_addr_i;
  logic              ld_use_i;
  logic              div_start_i;
  logic              div_done_i;
  logic              pc_jump_en_o;
  logic [ADDR_W-1:0] pc_jump_addr_o;
  logic [2:0]        stall_o;
  logic [1:0]        flush_o;
  logic              div_timeout_o;
  logic [1:0]        state_o;
`ifdef JUMP_CTRL_PERF_EN
  logic [31:0]       prd_cnt_o;
  logic [31:0]       miss_cnt_o;
`endif

  always #5 clk = ~clk;

  jump_ctrl #(
    .ADDR_W      (ADDR_W),
    .DIV_TIMEOUT (DIV_TIMEOUT),
    .CNT_W       (6)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .prd_jump_en_i      (prd_jump_en_i),
    .prd_jump_addr_i    (prd_jump_addr_i),
    .ex_redirect_en_i   (ex_redirect_en_i),
    .ex_redirect_addr_i (ex_redirect_addr_i),
    .ld_use_i           (ld_use_i),
    .div_start_i        (div_start_i),
    .div_done_i         (div_done_i),
    .pc_jump_en_o       (pc_jump_en_o),
    .pc_jump_addr_o     (pc_jump_addr_o),
    .stall_o            (stall_o),
    .flush_o            (flush_o),
    .div_timeout_o      (div_timeout_o),
    .state_o            (state_o)
`ifdef JUMP_CTRL_PERF_EN
    ,
    .prd_cnt_o          (prd_cnt_o),
    .miss_cnt_o         (miss_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model: "is a divide outstanding and for how long", "was last
  // cycle a redirect", "did a timeout just happen", plus event counters.
  bit          m_in_div;
  int          m_waited;
  bit          m_after_redirect;
  bit          m_timeout_pending;
  int unsigned m_prd_cnt;
  int unsigned m_miss_cnt;
  logic [2:0]  last_stall;

  task automatic model_reset();
    m_in_div          = 0;
    m_waited          = 0;
    m_after_redirect  = 0;
    m_timeout_pending = 0;
    m_prd_cnt         = 0;
    m_miss_cnt        = 0;
  endtask

  // One clock cycle: apply inputs after the falling edge, check, advance model.
  task automatic drive(input bit prd, input logic [31:0] pa, input bit ex,
                       input logic [31:0] ea, input bit ld, input bit ds, input bit dd);
    bit          e_jump;
    logic [31:0] e_addr;
    logic [2:0]  e_stall;
    logic [1:0]  e_flush;
    logic [1:0]  e_state;
    bit          n_in_div, n_after, n_tmo;
    int          n_waited;
    @(negedge clk);
    prd_jump_en_i      = prd;
    prd_jump_addr_i    = pa;
    ex_redirect_en_i   = ex;
    ex_redirect_addr_i = ea;
    ld_use_i           = ld;
    div_start_i        = ds;
    div_done_i         = dd;
    #1;
    e_jump = 0; e_addr = '0; e_stall = '0; e_flush = '0;
    e_state  = m_in_div ? 2'd1 : (m_after_redirect ? 2'd2 : 2'd0);
    n_in_div = 0; n_after = 0; n_tmo = 0; n_waited = 0;

    if (ex) begin
      e_jump = 1; e_addr = ea; e_flush = 2'b11;
      n_after = 1;
    end else if (m_in_div) begin
      if (dd) begin
        n_in_div = 0;
      end else if (m_waited == DIV_TIMEOUT - 1) begin
        n_tmo = 1;
      end else begin
        e_stall = 3'b111; n_in_div = 1; n_waited = m_waited + 1;
      end
    end else if (ds) begin
      if (!dd) begin
        e_stall = 3'b111; n_in_div = 1; n_waited = 0;
      end
    end else if (ld) begin
      e_stall = 3'b011; e_flush = 2'b10;
    end else if (prd && !m_after_redirect) begin
      e_jump = 1; e_addr = pa; e_flush = 2'b01;
    end

    check("pc_jump_en",   64'(pc_jump_en_o),   64'(e_jump));
    check("pc_jump_addr", 64'(pc_jump_addr_o), 64'(e_addr));
    check("stall",        64'(stall_o),        64'(e_stall));
    check("flush",        64'(flush_o),        64'(e_flush));
    check("state",        64'(state_o),        64'(e_state));
    check("div_timeout",  64'(div_timeout_o),  64'(m_timeout_pending));
`ifdef JUMP_CTRL_PERF_EN
    check("prd_cnt",      64'(prd_cnt_o),      64'(m_prd_cnt));
    check("miss_cnt",     64'(miss_cnt_o),     64'(m_miss_cnt));
`endif
    last_stall = stall_o;

    if (ex) m_miss_cnt++;
    if (e_jump && !ex) m_prd_cnt++;
    m_in_div          = n_in_div;
    m_waited          = n_waited;
    m_after_redirect  = n_after;
    m_timeout_pending = n_tmo;
  endtask

  task automatic idle();
    drive(0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    prd_jump_en_i = 0; prd_jump_addr_i = '0; ex_redirect_en_i = 0;
    ex_redirect_addr_i = '0; ld_use_i = 0; div_start_i = 0; div_done_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int stall_cycles;

  initial begin
    rstn = 1'b0;
    prd_jump_en_i = 0; prd_jump_addr_i = '0; ex_redirect_en_i = 0;
    ex_redirect_addr_i = '0; ld_use_i = 0; div_start_i = 0; div_done_i = 0;
    last_stall = '0;
    do_reset();

    // Reset state, then predicted jump in RUN.
    idle();
    drive(1, 32'h0000_0100, 0, '0, 0, 0, 0);
    // Predictor and EX in the same cycle; predictor re-asserted in RECOVER.
    drive(1, 32'h0000_0100, 1, 32'h0000_0200, 0, 0, 0);
    drive(1, 32'h0000_0100, 0, '0, 0, 0, 0);
    idle();

    // Divider finishing after 5 stalled cycles.
    stall_cycles = 0;
    drive(0, '0, 0, '0, 0, 1, 0);
    if (last_stall == 3'b111) stall_cycles++;
    repeat (4) begin
      idle();
      if (last_stall == 3'b111) stall_cycles++;
    end
    drive(0, '0, 0, '0, 0, 0, 1);
    idle();
    check("div_done_stall_len", 64'(stall_cycles), 64'd5);

    // Divider timeout: 40 held cycles, pulse one cycle after release.
    stall_cycles = 0;
    drive(0, '0, 0, '0, 0, 1, 0);
    if (last_stall == 3'b111) stall_cycles++;
    repeat (DIV_TIMEOUT) begin
      idle();
      if (last_stall == 3'b111) stall_cycles++;
    end
    idle();
    idle();
    check("div_timeout_stall_len", 64'(stall_cycles), 64'(DIV_TIMEOUT));

    // Single-cycle divide, load-use with predictor, divider with load-use.
    drive(0, '0, 0, '0, 0, 1, 1);
    drive(1, 32'h0000_0300, 0, '0, 1, 0, 0);
    drive(0, '0, 0, '0, 1, 1, 0);
    drive(1, 32'h0000_0400, 0, '0, 1, 0, 0);
    // Redirect aborting a divider wait, then redirect back-to-back.
    drive(0, '0, 1, 32'h0000_0500, 0, 0, 0);
    drive(0, '0, 1, 32'h0000_0600, 0, 0, 0);
    drive(0, '0, 0, '0, 1, 1, 0);
    repeat (5) idle();
    drive(0, '0, 1, 32'h0000_0700, 0, 0, 0);
    repeat (3) idle();

    // Asynchronous reset in the middle of a divider wait.
    drive(0, '0, 0, '0, 0, 1, 0);
    repeat (3) idle();
    @(negedge clk);
    prd_jump_en_i = 0; ex_redirect_en_i = 0; ld_use_i = 0;
    div_start_i = 0; div_done_i = 0;
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_stall", 64'(stall_o), 64'd0);
    check("async_rst_state", 64'(state_o), 64'd0);
    model_reset();
    @(posedge clk);
    #2;
    rstn = 1'b1;
    idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 2) == 0, $urandom, ($urandom % 12) == 0, $urandom,
            ($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 20) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
